// File: rtl/tqvp_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_bus_initiator
// Brief    : Single-command master for the TinyQV peripheral bus with timeout.
// Revision : 1.0
// ============================================================================
module tqvp_bus_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  per_address,
    output logic [31:0] per_wdata,
    output logic [1:0]  per_write_n,
    output logic [1:0]  per_read_n,
    input  logic [31:0] per_rdata,
    input  logic        per_ready,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WR   = 2'd1;
    localparam logic [1:0] c_ST_RD   = 2'd2;
    localparam logic [1:0] c_ST_RSP  = 2'd3;
    localparam logic [1:0] c_IDLE_N  = 2'b11;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_size;
    logic [5:0]  r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_count;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_masked;

    assign w_accept  = cmd_valid && (r_state == c_ST_IDLE);
    assign w_timeout = (r_count == c_TO_LAST);

    always_comb begin
        case (r_size)
            2'b00:   w_masked = {24'd0, per_rdata[7:0]};
            2'b01:   w_masked = {16'd0, per_rdata[15:0]};
            default: w_masked = per_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_size == 2'b11) begin
                        w_next_state = c_ST_RSP;
                    end else if (cmd_write) begin
                        w_next_state = c_ST_WR;
                    end else begin
                        w_next_state = c_ST_RD;
                    end
                end
            end
            c_ST_WR: w_next_state = c_ST_RSP;
            c_ST_RD: begin
                if (per_ready || w_timeout) begin
                    w_next_state = c_ST_RSP;
                end
            end
            c_ST_RSP: begin
                if (rsp_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Response fields are primed at accept so illegal sizes and writes need no later update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size  <= 2'b00;
            r_addr  <= 6'd0;
            r_wdata <= 32'd0;
            r_count <= 8'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_size  <= cmd_size;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_count <= 8'd0;
            r_rdata <= 32'd0;
            r_err   <= (cmd_size == 2'b11);
        end else if (r_state == c_ST_RD) begin
            if (per_ready) begin
                r_rdata <= w_masked;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    // Strobes decode straight from state so an async reset idles them at once.
    assign per_write_n = (r_state == c_ST_WR) ? r_size : c_IDLE_N;
    assign per_read_n  = (r_state == c_ST_RD) ? r_size : c_IDLE_N;
    assign per_address = r_addr;
    assign per_wdata   = r_wdata;
    assign cmd_ready   = (r_state == c_ST_IDLE);
    assign rsp_valid   = (r_state == c_ST_RSP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tqvp_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_bus_initiator
// Brief    : Vector table plus response scoreboard for tqvp_bus_initiator.
// Revision : 1.0
// ============================================================================
module tb_tqvp_bus_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  per_address;
    logic [31:0] per_wdata;
    logic [1:0]  per_write_n;
    logic [1:0]  per_read_n;
    logic [31:0] per_rdata;
    logic        per_ready;
    logic        busy;

    tqvp_bus_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .per_address(per_address), .per_wdata(per_wdata),
        .per_write_n(per_write_n), .per_read_n(per_read_n),
        .per_rdata(per_rdata), .per_ready(per_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          wait_cyc;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_strobes;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          strobes;
        int          lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   cyc;
        int   seen;
        bit   done;
        @(negedge clk);
        chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_size  = v.size;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        per_rdata = v.prdata;
        per_ready = 1'b0;
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        e.strobes = v.exp_strobes;
        e.lat     = v.exp_lat;
        sb.push_back(e);
        @(posedge clk);
        cyc  = 0;
        seen = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            cmd_addr  = 6'h3F;
            cmd_wdata = 32'hFFFF_FFFF;
            if (per_read_n != 2'b11 || per_write_n != 2'b11) begin
                seen++;
                chk("strobe_size", 32'(v.write ? per_write_n : per_read_n), 32'(v.size));
                chk("strobe_other", 32'(v.write ? per_read_n : per_write_n), 32'h3);
            end
            chk("per_address", 32'(per_address), 32'(v.addr));
            chk("per_wdata", per_wdata, v.wdata);
            if (rsp_valid) begin
                got = sb.pop_front();
                chk("rsp_latency", 32'(cyc), 32'(got.lat));
                chk("strobe_cycles", 32'(seen), 32'(got.strobes));
                chk("rsp_rdata", rsp_rdata, got.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(got.err));
                chk("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
                for (int h = 0; h < v.hold; h++) begin
                    per_ready = 1'b1;
                    @(negedge clk);
                    chk("hold_valid", 32'(rsp_valid), 32'd1);
                    chk("hold_rdata", rsp_rdata, got.rdata);
                    chk("hold_err", 32'(rsp_err), 32'(got.err));
                    chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
                    chk("hold_strobes", 32'({per_write_n, per_read_n}), 32'hF);
                end
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                per_ready = 1'b0;
                chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_strobes", 32'({per_write_n, per_read_n}), 32'hF);
                done = 1'b1;
            end else begin
                per_ready = (seen > v.wait_cyc);
                if (cyc > 200) begin
                    chk("rsp_wait_bound", 32'd0, 32'd1);
                    sb.delete();
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b10, 6'h20, 32'h12ABCDEF, 32'h0,        0,   0, 32'h0,        1'b0, 1,  2};
        vecs[1] = '{1'b0, 2'b00, 6'h18, 32'h0,        32'hDEADBE5A, 0,   0, 32'h0000005A, 1'b0, 1,  2};
        vecs[2] = '{1'b0, 2'b01, 6'h04, 32'h0,        32'h0000C3C3, 3,   0, 32'h0000C3C3, 1'b0, 4,  5};
        vecs[3] = '{1'b0, 2'b10, 6'h10, 32'h0,        32'hCAFEF00D, 255, 0, 32'h0,        1'b1, 16, 17};
        vecs[4] = '{1'b0, 2'b11, 6'h2A, 32'h0,        32'hDEADBE5A, 0,   0, 32'h0,        1'b1, 0,  1};
        vecs[5] = '{1'b1, 2'b11, 6'h15, 32'hFFFF0000, 32'hDEADBE5A, 0,   0, 32'h0,        1'b1, 0,  1};
        vecs[6] = '{1'b0, 2'b01, 6'h3F, 32'h0,        32'hDEADBE5A, 0,   5, 32'h0000BE5A, 1'b0, 1,  2};
        vecs[7] = '{1'b0, 2'b10, 6'h01, 32'h0,        32'h89ABCDEF, 1,   0, 32'h89ABCDEF, 1'b0, 2,  3};
        vecs[8] = '{1'b1, 2'b00, 6'h0C, 32'h000000A5, 32'h0,        0,   0, 32'h0,        1'b0, 1,  2};
        vecs[9] = '{1'b1, 2'b01, 6'h33, 32'h0000BEEF, 32'h0,        0,   2, 32'h0,        1'b0, 1,  2};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 2'b00;
        cmd_addr  = 6'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        per_rdata = 32'h0;
        per_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", 32'({per_write_n, per_read_n}), 32'hF);
        chk("rst_per_address", 32'(per_address), 32'd0);
        chk("rst_per_wdata", per_wdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a read wait, with a stray command offered while busy.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_size  = 2'b01;
        cmd_addr  = 6'h07;
        cmd_wdata = 32'h5555AAAA;
        per_ready = 1'b0;
        @(negedge clk);
        chk("mid_read_strobe", 32'(per_read_n), 32'h1);
        cmd_write = 1'b1;
        cmd_addr  = 6'h3F;
        cmd_wdata = 32'h0;
        @(negedge clk);
        chk("busy_ignore_addr", 32'(per_address), 32'h07);
        chk("busy_ignore_wdata", per_wdata, 32'h5555AAAA);
        chk("busy_ignore_write", 32'(per_write_n), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_read_n", 32'(per_read_n), 32'h3);
        chk("async_rst_write_n", 32'(per_write_n), 32'h3);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", 32'(per_address), 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_strobes", 32'({per_write_n, per_read_n}), 32'hF);
        chk("post_rst_err", 32'(rsp_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tqvp_bus_initiator.md
Name: tqvp_bus_initiator

Overview:
- Master-side driver for the TinyQV peripheral bus. Takes one command at a time over a valid/ready request channel and issues it as a single 8/16/32-bit read or write strobe toward a peripheral (e.g. tqvp_prism).
- Returns read data or a write acknowledge on a valid/ready response channel, with an error flag for a bus timeout or an illegal size.
- Used in bench harnesses and in the on-chip debug/config loader that programs peripherals without the CPU.

Parameters:
- TIMEOUT, 16, max cycles a read strobe is held waiting for per_ready before aborting with error (legal range 1..255).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  initiator idle, can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_size  input  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- cmd_addr  input  6  peripheral register address
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_rdata  output  32  read data, zero-extended per size; 0 for writes and errors
- rsp_err  output  1  1 = timeout or illegal size
- per_address  output  6  bus address
- per_wdata  output  32  bus write data
- per_write_n  output  2  11 = idle, else size code
- per_read_n  output  2  11 = idle, else size code
- per_rdata  input  32  peripheral read data
- per_ready  input  1  peripheral read-data-valid
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: clk clocks all state. rst_n is asynchronous, active-low.
- Reset values: state = IDLE; per_write_n = per_read_n = 11; per_address = 0; per_wdata = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; timeout counter = 0.
- Reset mid-transaction: strobes go to 11 immediately (async). Any pending command or response is discarded.
- States: IDLE, WR, RD, RSP.
- cmd_ready = (state == IDLE). A command is accepted on a clock edge with cmd_valid && cmd_ready. At accept, cmd_* is registered.
- per_address and per_wdata hold their value from one accept until the next accept.
- Accept with cmd_size == 11:
  - Go to RSP with rsp_err = 1, rsp_rdata = 0.
  - No strobe is ever driven.
- Accept write, size legal:
  - Go to WR. In WR, per_write_n = size for exactly one cycle.
  - Then go to RSP with rsp_err = 0, rsp_rdata = 0.
  - per_ready is ignored for writes.
- Accept read, size legal:
  - Go to RD with counter = 0. In RD, per_read_n = size; per_ready is sampled every cycle.
  - per_ready = 1: capture per_rdata masked to size (00 → bits [7:0], 01 → [15:0], 10 → [31:0], upper bits zero). Go to RSP with rsp_err = 0. per_read_n returns to 11 in the next cycle.
  - per_ready = 0: counter increments. When the counter reaches TIMEOUT−1 with per_ready still 0, go to RSP with rsp_err = 1, rsp_rdata = 0.
  - The strobe is therefore held at most TIMEOUT cycles.
- RSP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, return to IDLE. cmd_ready rises in the following cycle; there is no same-cycle response/command overlap.
- Latency, accept at edge N:
  - The strobe is active during cycle N+1.
  - With a zero-wait peripheral (per_ready tied 1), rsp_valid is asserted in cycle N+2 for both reads and writes.
  - A read that waits W cycles for per_ready gives rsp_valid at N+2+W.
- Exclusivity:
  - per_write_n and per_read_n are never both non-11.
  - Outside WR and RD, both strobes are 11.
- per_ready outside RD is ignored.
- cmd_valid while busy is ignored; the command is not latched.

Test Plan:
- 32-bit write: addr 0x20, wdata 0x12ABCDEF, size 10, per_ready = 1 → one cycle with per_write_n = 10, per_address = 0x20, per_wdata = 0x12ABCDEF. Then rsp_valid with rsp_err = 0, rsp_rdata = 0, at accept+2.
- Byte read: addr 0x18, size 00, per_rdata = 0xDEADBE5A, per_ready = 1 → per_read_n = 00 for one cycle. Then rsp_rdata = 0x0000005A and rsp_err = 0 at accept+2.
- Wait-state read, 16-bit: per_ready low for 3 cycles, then high with per_rdata = 0x0000C3C3 → per_read_n = 01 held 4 cycles. Then rsp_rdata = 0x0000C3C3 and rsp_valid at accept+5.
- Timeout: TIMEOUT = 16, per_ready stuck 0 → per_read_n held exactly 16 cycles. Then rsp_err = 1, rsp_rdata = 0, and per_read_n = 11 afterwards.
- Illegal size 11 (read and write cases) → rsp_err = 1 at accept+1, and both strobes stay 11 throughout.
- Backpressure plus reset:
  - rsp_ready held 0 for 5 cycles → rsp_valid, rsp_rdata, rsp_err stable, and cmd_ready = 0 throughout.
  - Then assert rst_n = 0 during a RD wait → strobes 11 immediately; after release, state is IDLE with cmd_ready = 1 and rsp_valid = 0.
